wave_addr_gen: RTL and testbench

WAVE_ADDR_GEN -- requirements
Module: wave_addr_gen

---
 rtl/wave_addr_gen_if.sv | 20 ++
 rtl/wave_addr_gen.sv | 90 +++++++++
 tb/tb_wave_addr_gen.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/wave_addr_gen_if.sv
// Control/status bundle for the wavetable address generator.
// master drives the advance controls; slave (the generator) returns address state.
interface wave_addr_gen_if #(
  parameter int ADDR_W = 12,
  parameter int STEP_W = 8
);
  logic              en;
  logic [STEP_W-1:0] step;
  logic [1:0]        mode;
  logic              load;
  logic [ADDR_W-1:0] load_val;
  logic [ADDR_W-1:0] address;
  logic              wrap;
  logic              dir;

  modport master (output en, step, mode, load, load_val,
                  input  address, wrap, dir);
  modport slave  (input  en, step, mode, load, load_val,
                  output address, wrap, dir);
endinterface

// File: rtl/wave_addr_gen.sv
// Wavetable address generator: modular up/down counting or ping-pong reflection
// over a table of DEPTH entries, with clamped step and clamped load.
module wave_addr_gen #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 32,
  parameter int STEP_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  wave_addr_gen_if.slave bus
);
  // One bit of headroom over the wider operand keeps a+s and 2*(DEPTH-1) exact.
  localparam int IW = ((ADDR_W > STEP_W) ? ADDR_W : STEP_W) + 1;
  localparam logic [IW-1:0] LAST  = IW'(DEPTH - 1);
  localparam logic [IW-1:0] DEP   = IW'(DEPTH);
  localparam logic [IW-1:0] TWICE = IW'(2 * (DEPTH - 1));

  typedef enum logic [1:0] {M_UP = 2'b00, M_DOWN = 2'b01, M_PING = 2'b10, M_HOLD = 2'b11} mode_e;

  logic [IW-1:0]     a, stp, s, sum, lv, nxt_a;
  logic [ADDR_W-1:0] nxt_addr;
  logic              nxt_dir, nxt_wrap;

  assign a   = IW'(bus.address);
  assign stp = IW'(bus.step);
  assign s   = (stp > LAST) ? LAST : stp;
  assign sum = a + s;
  assign lv  = IW'(bus.load_val);

  always_comb begin
    nxt_a    = a;
    nxt_dir  = bus.dir;
    nxt_wrap = 1'b0;
    if (bus.load) begin
      nxt_a   = (lv > LAST) ? LAST : lv;
      nxt_dir = 1'b1;
    end else if (bus.en) begin
      unique case (mode_e'(bus.mode))
        M_UP: begin
          nxt_dir = 1'b1;
          if (sum > LAST) begin
            nxt_a    = sum - DEP;
            nxt_wrap = 1'b1;
          end else nxt_a = sum;
        end
        M_DOWN: begin
          nxt_dir = 1'b0;
          if (a >= s) nxt_a = a - s;
          else begin
            nxt_a    = a + DEP - s;
            nxt_wrap = 1'b1;
          end
        end
        // Landing exactly on an end keeps direction; only passing it reflects.
        M_PING: begin
          if (bus.dir) begin
            if (sum > LAST) begin
              nxt_a    = TWICE - sum;
              nxt_dir  = 1'b0;
              nxt_wrap = 1'b1;
            end else nxt_a = sum;
          end else begin
            if (a >= s) nxt_a = a - s;
            else begin
              nxt_a    = s - a;
              nxt_dir  = 1'b1;
              nxt_wrap = 1'b1;
            end
          end
        end
        M_HOLD: ;
        default: ;
      endcase
    end
  end

  assign nxt_addr = ADDR_W'(nxt_a);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.address <= '0;
      bus.dir     <= 1'b1;
      bus.wrap    <= 1'b0;
    end else begin
      bus.address <= nxt_addr;
      bus.dir     <= nxt_dir;
      bus.wrap    <= nxt_wrap;
    end
  end
endmodule

// File: tb/tb_wave_addr_gen.sv
// Bench for wave_addr_gen: directed scenarios on DEPTH=32 and DEPTH=100 instances
// plus randomized traffic against an arithmetic reference model.
module tb_wave_addr_gen;
  localparam int AW = 12, SW = 8, D0 = 32, D1 = 100;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic          en = 1'b0, ld = 1'b0;
  logic [SW-1:0] st = '0;
  logic [1:0]    md = 2'b00;
  logic [AW-1:0] lv = '0;

  wave_addr_gen_if #(.ADDR_W(AW), .STEP_W(SW)) b0 ();
  wave_addr_gen_if #(.ADDR_W(AW), .STEP_W(SW)) b1 ();

  assign b0.en = en; assign b0.step = st; assign b0.mode = md; assign b0.load = ld; assign b0.load_val = lv;
  assign b1.en = en; assign b1.step = st; assign b1.mode = md; assign b1.load = ld; assign b1.load_val = lv;

  wave_addr_gen #(.ADDR_W(AW), .DEPTH(D0), .STEP_W(SW)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  wave_addr_gen #(.ADDR_W(AW), .DEPTH(D1), .STEP_W(SW)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  int checks = 0, errors = 0;
  int m0_a = 0, m1_a = 0;
  bit m0_d = 1, m1_d = 1, m0_w = 0, m1_w = 0;

  // Reference: table position as plain integers, modular wrap or mirror reflection.
  function automatic void model(input int d, input int a, input bit dr, input bit e, input bit l,
                                input int lval, input int stp, input int m,
                                output int na, output bit ndr, output bit nw);
    int s;
    s = (stp < d - 1) ? stp : d - 1;
    na = a; ndr = dr; nw = 0;
    if (l) begin
      na = (lval < d - 1) ? lval : d - 1;
      ndr = 1;
    end else if (e) begin
      case (m)
        0: begin na = (a + s) % d; nw = (a + s) >= d; ndr = 1; end
        1: begin na = (a - s + d) % d; nw = a < s; ndr = 0; end
        2: if (dr) begin
             if (a + s < d) na = a + s;
             else begin na = 2 * (d - 1) - (a + s); ndr = 0; nw = 1; end
           end else begin
             if (a >= s) na = a - s;
             else begin na = s - a; ndr = 1; nw = 1; end
           end
        default: ;
      endcase
    end
  endfunction

  task automatic reset_models();
    m0_a = 0; m1_a = 0; m0_d = 1; m1_d = 1; m0_w = 0; m1_w = 0;
  endtask

  task automatic tick();
    int na; bit nd, nw;
    @(posedge clk);
    if (rst) reset_models();
    else begin
      model(D0, m0_a, m0_d, en, ld, int'(lv), int'(st), int'(md), na, nd, nw);
      m0_a = na; m0_d = nd; m0_w = nw;
      model(D1, m1_a, m1_d, en, ld, int'(lv), int'(st), int'(md), na, nd, nw);
      m1_a = na; m1_d = nd; m1_w = nw;
    end
    #1;
  endtask

  task automatic test_reset();
    en = 1; ld = 1; lv = 12'd9; st = 8'd3;
    #12;
    checks++; if ({b0.address, b0.dir, b0.wrap} !== {12'd0, 1'b1, 1'b0}) begin errors++;
      $display("FAIL reset0 addr/dir/wrap=%0d/%0b/%0b expected 0/1/0", b0.address, b0.dir, b0.wrap); end
    checks++; if ({b1.address, b1.dir, b1.wrap} !== {12'd0, 1'b1, 1'b0}) begin errors++;
      $display("FAIL reset1 addr/dir/wrap=%0d/%0b/%0b expected 0/1/0", b1.address, b1.dir, b1.wrap); end
    tick();
    checks++; if (b0.address !== 12'd0) begin errors++;
      $display("FAIL reset_override addr=%0d expected 0", b0.address); end
    @(negedge clk); rst = 0; ld = 0; en = 0;
  endtask

  task automatic test_up_sweep();
    int e;
    md = 2'b00; st = 8'd1; en = 1; ld = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      e = (i + 1) % 32;
      checks++; if ({b0.address, b0.wrap, b0.dir} !== {12'(e), (e == 0), 1'b1}) begin errors++;
        $display("FAIL up_sweep[%0d] addr/wrap/dir=%0d/%0b/%0b expected %0d/%0b/1", i, b0.address, b0.wrap, b0.dir, e, e == 0); end
    end
  endtask

  task automatic test_load_clamp();
    ld = 1; lv = 12'd50; en = 1; md = 2'b00; st = 8'd1;
    tick();
    checks++; if ({b0.address, b0.dir, b0.wrap} !== {12'd31, 1'b1, 1'b0}) begin errors++;
      $display("FAIL load_clamp addr/dir/wrap=%0d/%0b/%0b expected 31/1/0", b0.address, b0.dir, b0.wrap); end
    ld = 0; st = 8'd40;
    tick();
    checks++; if ({b0.address, b0.wrap} !== {12'd30, 1'b1}) begin errors++;
      $display("FAIL step_clamp addr/wrap=%0d/%0b expected 30/1", b0.address, b0.wrap); end
  endtask

  task automatic test_depth100();
    ld = 1; lv = 12'd95; md = 2'b00; st = 8'd7; en = 1;
    tick();
    ld = 0;
    tick();
    checks++; if ({b1.address, b1.wrap} !== {12'd2, 1'b1}) begin errors++;
      $display("FAIL d100_wrap addr/wrap=%0d/%0b expected 2/1", b1.address, b1.wrap); end
    tick();
    checks++; if ({b1.address, b1.wrap} !== {12'd9, 1'b0}) begin errors++;
      $display("FAIL d100_next addr/wrap=%0d/%0b expected 9/0", b1.address, b1.wrap); end
  endtask

  task automatic test_down();
    ld = 1; lv = 12'd1; md = 2'b01; st = 8'd3; en = 1;
    tick();
    ld = 0;
    tick();
    checks++; if ({b0.address, b0.wrap, b0.dir} !== {12'd30, 1'b1, 1'b0}) begin errors++;
      $display("FAIL down_wrap addr/wrap/dir=%0d/%0b/%0b expected 30/1/0", b0.address, b0.wrap, b0.dir); end
    tick();
    checks++; if ({b0.address, b0.wrap} !== {12'd27, 1'b0}) begin errors++;
      $display("FAIL down_next addr/wrap=%0d/%0b expected 27/0", b0.address, b0.wrap); end
  endtask

  task automatic test_pingpong();
    ld = 1; lv = 12'd29; md = 2'b10; st = 8'd5; en = 1;
    tick(); ld = 0;
    tick();
    checks++; if ({b0.address, b0.dir, b0.wrap} !== {12'd28, 1'b0, 1'b1}) begin errors++;
      $display("FAIL pp_top addr/dir/wrap=%0d/%0b/%0b expected 28/0/1", b0.address, b0.dir, b0.wrap); end
    tick();
    checks++; if ({b0.address, b0.dir, b0.wrap} !== {12'd23, 1'b0, 1'b0}) begin errors++;
      $display("FAIL pp_down addr/dir/wrap=%0d/%0b/%0b expected 23/0/0", b0.address, b0.dir, b0.wrap); end
    ld = 1; lv = 12'd7; tick(); ld = 0; md = 2'b01;
    tick();
    md = 2'b10;
    tick();
    checks++; if ({b0.address, b0.dir, b0.wrap} !== {12'd3, 1'b1, 1'b1}) begin errors++;
      $display("FAIL pp_bottom addr/dir/wrap=%0d/%0b/%0b expected 3/1/1", b0.address, b0.dir, b0.wrap); end
    ld = 1; lv = 12'd26; tick(); ld = 0;
    tick();
    checks++; if ({b0.address, b0.dir, b0.wrap} !== {12'd31, 1'b1, 1'b0}) begin errors++;
      $display("FAIL pp_land_top addr/dir/wrap=%0d/%0b/%0b expected 31/1/0", b0.address, b0.dir, b0.wrap); end
    tick();
    checks++; if ({b0.address, b0.dir, b0.wrap} !== {12'd26, 1'b0, 1'b1}) begin errors++;
      $display("FAIL pp_pass_top addr/dir/wrap=%0d/%0b/%0b expected 26/0/1", b0.address, b0.dir, b0.wrap); end
    st = 8'd26;
    tick();
    checks++; if ({b0.address, b0.dir, b0.wrap} !== {12'd0, 1'b0, 1'b0}) begin errors++;
      $display("FAIL pp_land_zero addr/dir/wrap=%0d/%0b/%0b expected 0/0/0", b0.address, b0.dir, b0.wrap); end
    tick();
    checks++; if ({b0.address, b0.dir, b0.wrap} !== {12'd26, 1'b1, 1'b1}) begin errors++;
      $display("FAIL pp_pass_zero addr/dir/wrap=%0d/%0b/%0b expected 26/1/1", b0.address, b0.dir, b0.wrap); end
  endtask

  task automatic test_hold_zero_step();
    md = 2'b11; st = 8'd9; en = 1;
    tick();
    checks++; if ({b0.address, b0.dir, b0.wrap} !== {12'd26, 1'b1, 1'b0}) begin errors++;
      $display("FAIL hold addr/dir/wrap=%0d/%0b/%0b expected 26/1/0", b0.address, b0.dir, b0.wrap); end
    st = 8'd0;
    for (int m = 0; m < 3; m++) begin
      md = 2'(m);
      tick();
      checks++; if ({b0.address, b0.wrap} !== {12'd26, 1'b0}) begin errors++;
        $display("FAIL zero_step[%0d] addr/wrap=%0d/%0b expected 26/0", m, b0.address, b0.wrap); end
    end
    en = 0; md = 2'b00; st = 8'd4;
    tick();
    checks++; if ({b0.address, b0.dir, b0.wrap} !== {12'd26, 1'b0, 1'b0}) begin errors++;
      $display("FAIL en_low addr/dir/wrap=%0d/%0b/%0b expected 26/0/0", b0.address, b0.dir, b0.wrap); end
  endtask

  task automatic test_async_reset();
    ld = 1; lv = 12'd16; md = 2'b00; st = 8'd1; en = 1;
    tick(); ld = 0;
    tick();
    #2 rst = 1;
    #1;
    checks++; if ({b0.address, b0.wrap, b0.dir} !== {12'd0, 1'b0, 1'b1}) begin errors++;
      $display("FAIL async_rst addr/wrap/dir=%0d/%0b/%0b expected 0/0/1", b0.address, b0.wrap, b0.dir); end
    reset_models();
    ld = 1; lv = 12'd5;
    tick();
    #2 rst = 0; ld = 0;
    tick();
    checks++; if (b0.address !== 12'd1) begin errors++;
      $display("FAIL resume1 addr=%0d expected 1", b0.address); end
    tick();
    checks++; if (b0.address !== 12'd2) begin errors++;
      $display("FAIL resume2 addr=%0d expected 2", b0.address); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 15) == 0);
      lv = ($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 120)) : 12'($urandom);
      st = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      md = 2'($urandom_range(0, 3));
      tick();
      checks++; if ({b0.address, b0.dir, b0.wrap} !== {12'(m0_a), m0_d, m0_w}) begin errors++;
        $display("FAIL rand0[%0d] addr/dir/wrap=%0d/%0b/%0b expected %0d/%0b/%0b", i, b0.address, b0.dir, b0.wrap, m0_a, m0_d, m0_w); end
      checks++; if ({b1.address, b1.dir, b1.wrap} !== {12'(m1_a), m1_d, m1_w}) begin errors++;
        $display("FAIL rand1[%0d] addr/dir/wrap=%0d/%0b/%0b expected %0d/%0b/%0b", i, b1.address, b1.dir, b1.wrap, m1_a, m1_d, m1_w); end
    end
  endtask

  initial begin
    test_reset();
    test_up_sweep();
    test_load_clamp();
    test_depth100();
    test_down();
    test_pingpong();
    test_hold_zero_step();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout after 500000 time units");
    $fatal(1);
  end
endmodule
